// File: rtl/reg_xfer_seq.sv
// rtl/reg_xfer_seq.sv - register-to-register byte-lane transfer sequencer (IDLE/RD/WR/FIN)
// Optional macro XFER_SWAP_EN enables the hi/lo byte swap on the write phase.
module reg_xfer_seq (
  input  logic        clk,
  input  logic        nreset,
  input  logic        req,
  input  logic [3:0]  src,
  input  logic [3:0]  dst,
  input  logic        hi_en,
  input  logic        lo_en,
  input  logic        swap,
  input  logic [7:0]  db_hi_in,
  input  logic [7:0]  db_lo_in,
  output logic [11:0] sel_gp,
  output logic        sel_pc,
  output logic        sel_ir,
  output logic        sel_gp_hi,
  output logic        sel_gp_lo,
  output logic        gp_oe,
  output logic        sel_sys_hi,
  output logic        sel_sys_lo,
  output logic        sys_oe,
  output logic [7:0]  db_hi_out,
  output logic [7:0]  db_lo_out,
  output logic        db_hi_drv,
  output logic        db_lo_drv,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

  state_t      state, state_n;
  logic [3:0]  src_q, src_n, dst_q, dst_n, code;
  logic        hi_q, hi_n, lo_q, lo_n, swap_q, swap_n, swap_eff, req_ok;
  logic [7:0]  hold_hi, hold_hi_n, hold_lo, hold_lo_n;
  logic [11:0] sel_gp_n;
  logic        sel_pc_n, sel_ir_n, sel_gp_hi_n, sel_gp_lo_n, gp_oe_n;
  logic        sel_sys_hi_n, sel_sys_lo_n, sys_oe_n;
  logic [7:0]  db_hi_out_n, db_lo_out_n;
  logic        db_hi_drv_n, db_lo_drv_n, busy_n, done_n, err_n;

  assign req_ok = (src < 4'd14) && (dst < 4'd14) && (hi_en || lo_en);

  // Outputs are decoded from the next state so every port comes straight from a flop.
  always_comb begin
    state_n      = state;
    src_n        = src_q;
    dst_n        = dst_q;
    hi_n         = hi_q;
    lo_n         = lo_q;
    swap_n       = swap_q;
    hold_hi_n    = hold_hi;
    hold_lo_n    = hold_lo;
    code         = 4'd0;
    sel_gp_n     = 12'd0;
    sel_pc_n     = 1'b0;
    sel_ir_n     = 1'b0;
    sel_gp_hi_n  = 1'b0;
    sel_gp_lo_n  = 1'b0;
    gp_oe_n      = 1'b0;
    sel_sys_hi_n = 1'b0;
    sel_sys_lo_n = 1'b0;
    sys_oe_n     = 1'b0;
    db_hi_out_n  = 8'd0;
    db_lo_out_n  = 8'd0;
    db_hi_drv_n  = 1'b0;
    db_lo_drv_n  = 1'b0;
    err_n        = 1'b0;

    case (state)
      IDLE: begin
        if (req) begin
          if (req_ok) begin
            state_n = RD;
            src_n   = src;
            dst_n   = dst;
            hi_n    = hi_en;
            lo_n    = lo_en;
            swap_n  = swap;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      RD: begin
        state_n = WR;
        if (hi_q) hold_hi_n = db_hi_in;
        if (lo_q) hold_lo_n = db_lo_in;
      end
      WR:      state_n = FIN;
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase

`ifdef XFER_SWAP_EN
    swap_eff = swap_n;
`else
    swap_eff = 1'b0;
`endif

    busy_n = (state_n != IDLE);
    done_n = (state_n == FIN);

    if (state_n == RD || state_n == WR) begin
      code = (state_n == RD) ? src_n : dst_n;
      if (code < 4'd12) begin
        sel_gp_n    = 12'd1 << code;
        sel_gp_hi_n = hi_n;
        sel_gp_lo_n = lo_n;
        gp_oe_n     = (state_n == RD);
      end else begin
        sel_pc_n     = (code == 4'd12);
        sel_ir_n     = (code == 4'd13);
        sel_sys_hi_n = hi_n;
        sel_sys_lo_n = lo_n;
        sys_oe_n     = (state_n == RD);
      end
    end

    // Drive only in WR, so output enables and bus drivers can never overlap.
    if (state_n == WR) begin
      db_hi_out_n = swap_eff ? hold_lo_n : hold_hi_n;
      db_lo_out_n = swap_eff ? hold_hi_n : hold_lo_n;
      db_hi_drv_n = hi_n;
      db_lo_drv_n = lo_n;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state      <= IDLE;
      src_q      <= 4'd0;
      dst_q      <= 4'd0;
      hi_q       <= 1'b0;
      lo_q       <= 1'b0;
      swap_q     <= 1'b0;
      hold_hi    <= 8'd0;
      hold_lo    <= 8'd0;
      sel_gp     <= 12'd0;
      sel_pc     <= 1'b0;
      sel_ir     <= 1'b0;
      sel_gp_hi  <= 1'b0;
      sel_gp_lo  <= 1'b0;
      gp_oe      <= 1'b0;
      sel_sys_hi <= 1'b0;
      sel_sys_lo <= 1'b0;
      sys_oe     <= 1'b0;
      db_hi_out  <= 8'd0;
      db_lo_out  <= 8'd0;
      db_hi_drv  <= 1'b0;
      db_lo_drv  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      src_q      <= src_n;
      dst_q      <= dst_n;
      hi_q       <= hi_n;
      lo_q       <= lo_n;
      swap_q     <= swap_n;
      hold_hi    <= hold_hi_n;
      hold_lo    <= hold_lo_n;
      sel_gp     <= sel_gp_n;
      sel_pc     <= sel_pc_n;
      sel_ir     <= sel_ir_n;
      sel_gp_hi  <= sel_gp_hi_n;
      sel_gp_lo  <= sel_gp_lo_n;
      gp_oe      <= gp_oe_n;
      sel_sys_hi <= sel_sys_hi_n;
      sel_sys_lo <= sel_sys_lo_n;
      sys_oe     <= sys_oe_n;
      db_hi_out  <= db_hi_out_n;
      db_lo_out  <= db_lo_out_n;
      db_hi_drv  <= db_hi_drv_n;
      db_lo_drv  <= db_lo_drv_n;
      busy       <= busy_n;
      done       <= done_n;
      err        <= err_n;
    end
  end

endmodule

// File: doc/reg_xfer_seq.md
REG_XFER_SEQ -- requirements
Module: reg_xfer_seq

Interface
REQ-001 The block SHALL have one clock and reset, which is asynchronous and active-low, listed first: clk  in  1  rising-edge clock; nreset  in  1  async active-low reset.
REQ-002 The block SHALL have these request inputs: req  in  1  transfer request; src  in  4  source register code; dst  in  4  destination register code; hi_en  in  1  high-byte lane enable; lo_en  in  1  low-byte lane enable; swap  in  1  byte-swap request.
REQ-003 The block SHALL have these data inputs: db_hi_in  in  8  data-side high bus sample; db_lo_in  in  8  data-side low bus sample.
REQ-004 The block SHALL have these register-file control outputs: sel_gp  out  12  one-hot select, bits 0..11 = AF,AF2,BC,BC2,DE,DE2,HL,HL2,IX,IY,WZ,SP; sel_pc  out  1; sel_ir  out  1; sel_gp_hi, sel_gp_lo, gp_oe  out  1 each; sel_sys_hi, sel_sys_lo, sys_oe  out  1 each.
REQ-005 The block SHALL have these bus-drive outputs: db_hi_out, db_lo_out  out  8 each  held data; db_hi_drv, db_lo_drv  out  1 each  lane drive enable (tri-state control).
REQ-006 The block SHALL have these status outputs: busy  out  1  transfer in progress; done  out  1  one-cycle completion pulse; err  out  1  one-cycle rejection pulse.

Function
REQ-007 Register codes SHALL map 0..11 to sel_gp bits 0..11, 12 to PC and 13 to IR; codes 14 and 15 SHALL be invalid.
REQ-008 The FSM SHALL have four states, IDLE, RD, WR and FIN, and all outputs SHALL be registered (Moore).
REQ-009 In IDLE, req=1 with valid src and dst and hi_en|lo_en=1 SHALL latch src, dst, hi_en, lo_en and swap, then go to RD on the next edge.
REQ-010 In IDLE, req=1 with an invalid code or hi_en=lo_en=0 SHALL pulse err for one cycle, assert no select, and stay in IDLE.
REQ-011 In RD, the block SHALL assert the source select: sel_gp bit with gp_oe for codes 0..11, or sel_pc/sel_ir with sys_oe for codes 12..13.
REQ-012 In RD, the byte selects SHALL equal the latched lane enables: sel_gp_hi/lo for GP codes, sel_sys_hi/lo for system codes.
REQ-013 On the RD->WR edge, the block SHALL capture db_hi_in/db_lo_in into the holding register; disabled lanes SHALL keep their previous value.
REQ-014 In WR, the block SHALL assert the destination select and byte selects with oe deasserted, and SHALL set db_*_drv=1 on enabled lanes only.
REQ-015 WR->FIN SHALL be unconditional; in FIN all selects and drives SHALL be 0 and done=1 for one cycle; FIN->IDLE SHALL be unconditional.
REQ-016 busy SHALL be 1 in RD, WR and FIN, and 0 in IDLE.
REQ-017 Request-to-done latency SHALL be 3 cycles, and a back-to-back req SHALL be accepted no earlier than the IDLE cycle after FIN.
REQ-018 req SHALL be ignored while busy=1; the request inputs SHALL NOT be sampled outside IDLE.
REQ-019 src==dst SHALL be legal and SHALL perform a read-then-rewrite of the same register.
REQ-020 gp_oe/sys_oe and db_*_drv SHALL never both be 1 in the same cycle, so there is no bus contention.

Reset
REQ-021 nreset=0 SHALL force IDLE asynchronously and clear every output, the holding register and the latched request to 0, including mid-transfer.
REQ-022 After nreset rises, the first req SHALL be accepted on the first clk edge.

Configuration
REQ-023 With macro XFER_SWAP_EN defined and latched swap=1, WR SHALL drive db_hi_out=held low byte and db_lo_out=held high byte, with lane enables applied to destination lanes.
REQ-024 Without XFER_SWAP_EN, the swap input SHALL be ignored, the port SHALL remain present, and data SHALL always pass lane-straight.

Verification
REQ-025 Reset, then req src=0(AF) dst=2(BC) hi_en=lo_en=1 with db_hi_in=34h and db_lo_in=12h in RD -> RD: sel_gp=001h, gp_oe=1; WR: sel_gp=004h, db_hi_out=34h, db_lo_out=12h, both drv=1; done on cycle 3.
REQ-026 req src=12(PC) dst=10(WZ) with lo_en only and db_lo_in=5Ah -> RD: sel_pc, sys_oe, sel_sys_lo; WR: sel_gp=400h, sel_gp_lo, db_lo_drv=1 with db_lo_out=5Ah, db_hi_drv=0.
REQ-027 req with src=14, then req with hi_en=lo_en=0 -> err pulses for one cycle each, busy stays 0, all selects stay 0.
REQ-028 req held high continuously for two transfers -> second RD begins exactly 4 cycles after the first; req is ignored during busy.
REQ-029 nreset pulsed low during WR -> outputs zero immediately without waiting for clk, FSM is in IDLE, and no done pulse occurs.
REQ-030 With XFER_SWAP_EN, swap=1, and bus inputs ABh/CDh -> WR drives CDh/ABh; the same stimulus without the macro -> WR drives ABh/CDh.
